// File: rtl/baccarat_if.sv
// baccarat_if: score inputs, card-load strobes and result lights between the sequencer and the datapath.
interface baccarat_if;
    logic [3:0] pscore_in;
    logic [3:0] dscore_in;
    logic [3:0] pcard3_in;
    logic load_pcard1;
    logic load_pcard2;
    logic load_pcard3;
    logic load_dcard1;
    logic load_dcard2;
    logic load_dcard3;
    logic player_win_light;
    logic dealer_win_light;
    logic hand_done;
    modport master (
        input  pscore_in, dscore_in, pcard3_in,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, hand_done
    );
    modport slave (
        output pscore_in, dscore_in, pcard3_in,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, hand_done
    );
endinterface

// File: rtl/baccarat_sequencer.sv
// baccarat_sequencer: Moore FSM dealing one baccarat hand, applying third-card rules and latching win lights.
module baccarat_sequencer #(
    parameter logic [3:0] NATURAL_MIN = 4'd8,
    parameter logic [3:0] DRAW_MAX    = 4'd5
) (
    input logic slow_clock,
    input logic reset,
    baccarat_if.master bus
);
    typedef enum logic [3:0] {
        S_RESET, S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_BANK, S_D3, S_SCORE, S_DONE
    } state_t;
    state_t state, next;
    logic player_win, dealer_win;
    logic [3:0] v;
    logic bank_draw;
    assign v = bus.pcard3_in >= 4'd10 ? 4'd0 : bus.pcard3_in;
    assign bank_draw = (bus.dscore_in <= 4'd2) ||
                       (bus.dscore_in == 4'd3 && v != 4'd8) ||
                       (bus.dscore_in == 4'd4 && v >= 4'd2 && v <= 4'd7) ||
                       (bus.dscore_in == 4'd5 && v >= 4'd4 && v <= 4'd7) ||
                       (bus.dscore_in == 4'd6 && v >= 4'd6 && v <= 4'd7);
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state      <= S_RESET;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
        end else begin
            state <= next;
            if (state == S_SCORE) begin
                player_win <= bus.pscore_in >= bus.dscore_in;
                dealer_win <= bus.dscore_in >= bus.pscore_in;
            end
        end
    end
    always_comb begin
        next = state;
        case (state)
            S_RESET: next = S_P1;
            S_P1:    next = S_D1;
            S_D1:    next = S_P2;
            S_P2:    next = S_D2;
            S_D2:    next = S_EVAL;
            S_EVAL:  next = (bus.pscore_in >= NATURAL_MIN || bus.dscore_in >= NATURAL_MIN) ? S_SCORE :
                            (bus.pscore_in <= DRAW_MAX) ? S_P3 :
                            (bus.dscore_in <= DRAW_MAX) ? S_D3 : S_SCORE;
            S_P3:    next = S_BANK;
            S_BANK:  next = bank_draw ? S_D3 : S_SCORE;
            S_D3:    next = S_SCORE;
            S_SCORE: next = S_DONE;
            S_DONE:  next = S_DONE;
            default: next = S_RESET;
        endcase
    end
    assign bus.load_pcard1      = state == S_P1;
    assign bus.load_dcard1      = state == S_D1;
    assign bus.load_pcard2      = state == S_P2;
    assign bus.load_dcard2      = state == S_D2;
    assign bus.load_pcard3      = state == S_P3;
    assign bus.load_dcard3      = state == S_D3;
    assign bus.hand_done        = state == S_DONE;
    assign bus.player_win_light = player_win;
    assign bus.dealer_win_light = dealer_win;
endmodule

// File: tb/tb_baccarat_sequencer.sv
// tb_baccarat_sequencer: directed hands; expected per-cycle outputs are queued when a hand is planned and popped each edge.
module tb_baccarat_sequencer;
    localparam int R = 0, P1 = 1, D1 = 2, P2 = 3, D2 = 4, EV = 5, P3 = 6, BK = 7, D3 = 8, SC = 9, DN = 10;
    logic slow_clock = 1'b0;
    logic reset = 1'b1;
    baccarat_if bus();
    baccarat_sequencer dut (.slow_clock(slow_clock), .reset(reset), .bus(bus));
    always #5 slow_clock = ~slow_clock;
    int checks = 0, failures = 0;
    int st_q[$];
    logic [8:0] exp_q[$];
    logic [3:0] ep, ed, pc3, fp, fd;
    logic [8:0] obs;
    assign obs = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2,
                  bus.load_pcard3, bus.load_dcard3, bus.player_win_light, bus.dealer_win_light, bus.hand_done};

    function automatic logic [8:0] outs(int s, logic pw, logic dw);
        return {s == P1, s == D1, s == P2, s == D2, s == P3, s == D3, (s == DN) & pw, (s == DN) & dw, s == DN};
    endfunction

    function automatic logic banker(logic [3:0] d, logic [3:0] c);
        int v;
        v = (c > 4'd9) ? 0 : int'(c);
        case (d)
            4'd0, 4'd1, 4'd2: return 1'b1;
            4'd3: return v != 8;
            4'd4: return v inside {[2:7]};
            4'd5: return v inside {[4:7]};
            4'd6: return v inside {[6:7]};
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(string tag, logic [8:0] got, logic [8:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic push(int s, logic pw, logic dw);
        st_q.push_back(s);
        exp_q.push_back(outs(s, pw, dw));
    endtask

    task automatic plan(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] f, logic [3:0] g);
        logic pw, dw;
        ep = a; ed = b; pc3 = c; fp = f; fd = g;
        pw = f >= g;
        dw = g >= f;
        push(P1, pw, dw); push(D1, pw, dw); push(P2, pw, dw); push(D2, pw, dw); push(EV, pw, dw);
        if (a >= 4'd8 || b >= 4'd8) begin
        end else if (a <= 4'd5) begin
            push(P3, pw, dw);
            push(BK, pw, dw);
            if (banker(b, c)) push(D3, pw, dw);
        end else if (b <= 4'd5) begin
            push(D3, pw, dw);
        end
        push(SC, pw, dw);
        push(DN, pw, dw); push(DN, pw, dw); push(DN, pw, dw);
    endtask

    task automatic run(int n, string tag);
        int s;
        logic [8:0] e;
        int k = 0;
        while (st_q.size() > 0 && (n < 0 || k < n)) begin
            @(posedge slow_clock);
            #1;
            s = st_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s state%0d", tag, s), obs, e);
            bus.pscore_in = 4'($urandom_range(0, 15));
            bus.dscore_in = 4'($urandom_range(0, 15));
            bus.pcard3_in = 4'($urandom_range(0, 15));
            if (s == EV) begin
                bus.pscore_in = ep; bus.dscore_in = ed;
            end else if (s == BK) begin
                bus.dscore_in = ed; bus.pcard3_in = pc3;
            end else if (s == SC) begin
                bus.pscore_in = fp; bus.dscore_in = fd;
            end
            k++;
        end
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge slow_clock);
            #1;
            check("reset", obs, 9'd0);
        end
        reset = 1'b0;
        st_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.pscore_in = 4'd0;
        bus.dscore_in = 4'd0;
        bus.pcard3_in = 4'd0;
        do_reset(2);
        plan(4'd8, 4'd3, 4'd0, 4'd8, 4'd3);   run(-1, "natural");
        do_reset(1);
        plan(4'd5, 4'd3, 4'd13, 4'd5, 4'd7);  run(-1, "both_draw");
        do_reset(1);
        plan(4'd2, 4'd6, 4'd6, 4'd7, 4'd6);   run(-1, "bank_d6_c6");
        do_reset(1);
        plan(4'd2, 4'd6, 4'd5, 4'd7, 4'd6);   run(-1, "bank_d6_c5");
        do_reset(1);
        plan(4'd2, 4'd3, 4'd8, 4'd4, 4'd4);   run(-1, "bank_d3_c8_tie");
        do_reset(1);
        plan(4'd3, 4'd4, 4'd11, 4'd9, 4'd2);  run(-1, "bank_d4_face");
        do_reset(1);
        plan(4'd7, 4'd5, 4'd0, 4'd7, 4'd9);   run(-1, "player_stands");
        do_reset(1);
        plan(4'd6, 4'd7, 4'd0, 4'd6, 4'd7);   run(-1, "both_stand");
        do_reset(1);
        plan(4'd5, 4'd3, 4'd13, 4'd5, 4'd7);  run(6, "pre_reset");
        do_reset(1);
        plan(4'd1, 4'd1, 4'd2, 4'd3, 4'd3);   run(-1, "after_reset");
        do_reset(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
